// File: rtl/data_stack.sv
// Register-array data stack with single-cycle push, pop-one, pop-two and
// rotate-into-top, plus a saturating occupancy count and sticky error flags.
module data_stack #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned DEPTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  halt,
   input  logic [1:0]            movement,
   input  logic [WORD_WIDTH-1:0] next_top,
   input  logic                  rotate,
   input  logic [4:0]            rotate_addr,
   output logic [WORD_WIDTH-1:0] top,
   output logic [WORD_WIDTH-1:0] second,
   output logic [WORD_WIDTH-1:0] third,
   output logic [WORD_WIDTH-1:0] rotate_value,
   output logic [5:0]            count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned CW = 6;
   localparam int unsigned AW = 5;

   localparam logic [1:0] MV_NONE = 2'b00;
   localparam logic [1:0] MV_PUSH = 2'b01;
   localparam logic [1:0] MV_POP1 = 2'b10;
   localparam logic [1:0] MV_POP2 = 2'b11;

   logic [WORD_WIDTH-1:0] entry     [DEPTH];
   logic [WORD_WIDTH-1:0] entry_nxt [DEPTH];
   logic [CW-1:0]         count_nxt;
   logic                  overflow_set;
   logic                  underflow_set;
   logic [CW-1:0]         addr_ext;
   logic                  full;

   assign addr_ext = {1'b0, rotate_addr};
   assign full     = (count == CW'(DEPTH));

   // Next entry contents; the top always takes next_top.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_nxt[i] = entry[i];
      end
      case (movement)
         MV_PUSH: begin
            for (int i = 1; i < DEPTH; i++) begin
               entry_nxt[i] = entry[i-1];
            end
         end
         MV_POP1: begin
            for (int i = 1; i < DEPTH - 1; i++) begin
               entry_nxt[i] = entry[i+1];
            end
            entry_nxt[DEPTH-1] = '0;
         end
         MV_POP2: begin
            for (int i = 1; i < DEPTH - 2; i++) begin
               entry_nxt[i] = entry[i+2];
            end
            entry_nxt[DEPTH-2] = '0;
            entry_nxt[DEPTH-1] = '0;
         end
         default: begin
            if (rotate) begin
               for (int i = 1; i < DEPTH; i++) begin
                  if (AW'(i) <= rotate_addr) begin
                     entry_nxt[i] = entry[i-1];
                  end
               end
            end
         end
      endcase
      entry_nxt[0] = next_top;
   end

   // Count update and error detection. A push is checked as a copy only when
   // the caller flags it by also raising rotate.
   always_comb begin
      count_nxt     = count;
      overflow_set  = 1'b0;
      underflow_set = 1'b0;
      case (movement)
         MV_PUSH: begin
            if (full) begin
               overflow_set = 1'b1;
            end else begin
               count_nxt     = count + CW'(1);
               underflow_set = rotate && (addr_ext >= count);
            end
         end
         MV_POP1: begin
            underflow_set = (count < CW'(2));
            count_nxt     = (count == '0) ? '0 : count - CW'(1);
         end
         MV_POP2: begin
            underflow_set = (count < CW'(3));
            count_nxt     = (count < CW'(2)) ? '0 : count - CW'(2);
         end
         default: begin
            underflow_set = rotate && (addr_ext >= count);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (!halt) begin
         entry     <= entry_nxt;
         count     <= count_nxt;
         overflow  <= overflow | overflow_set;
         underflow <= underflow | underflow_set;
      end
   end

   assign top          = entry[0];
   assign second       = entry[1];
   assign third        = entry[2];
   assign rotate_value = entry[rotate_addr];

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: a behavioural stack model feeds a
// queue of expected states that is compared one cycle after each operation.
module tb_data_stack;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt;
   logic [1:0]  movement;
   logic [31:0] next_top;
   logic        rotate;
   logic [4:0]  rotate_addr;
   logic [31:0] top, second, third, rotate_value;
   logic [5:0]  count;
   logic        overflow, underflow;

   typedef struct packed {
      logic [31:0] t;
      logic [31:0] s;
      logic [31:0] th;
      logic [5:0]  c;
      logic        o;
      logic        u;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m [32];
   int          mcount;
   logic        mov, mud;
   int          n_tests = 0;
   int          n_fail  = 0;

   data_stack dut (
      .clk(clk), .reset(reset), .halt(halt), .movement(movement),
      .next_top(next_top), .rotate(rotate), .rotate_addr(rotate_addr),
      .top(top), .second(second), .third(third), .rotate_value(rotate_value),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mget(input int i);
      return (i < 32) ? m[i] : 32'h0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m[i] = '0;
      mcount = 0;
      mov    = 1'b0;
      mud    = 1'b0;
   endtask

   task automatic model_step(input logic h, input logic [1:0] mv, input logic [31:0] nt,
                             input logic rot, input logic [4:0] ad);
      logic [31:0] old [32];
      if (h) return;
      old = m;
      case (mv)
         2'b00: if (rot) begin
            for (int i = 1; i <= int'(ad); i++) m[i] = old[i-1];
            if (int'(ad) >= mcount) mud = 1'b1;
         end
         2'b01: begin
            for (int i = 1; i < 32; i++) m[i] = old[i-1];
            if (mcount == 32) mov = 1'b1;
            else begin
               if (rot && int'(ad) >= mcount) mud = 1'b1;
               mcount++;
            end
         end
         2'b10: begin
            for (int i = 1; i < 32; i++) m[i] = (i + 1 < 32) ? old[i+1] : 32'h0;
            if (mcount < 2) mud = 1'b1;
            mcount = (mcount > 0) ? mcount - 1 : 0;
         end
         default: begin
            for (int i = 1; i < 32; i++) m[i] = (i + 2 < 32) ? old[i+2] : 32'h0;
            if (mcount < 3) mud = 1'b1;
            mcount = (mcount > 1) ? mcount - 2 : 0;
         end
      endcase
      m[0] = nt;
   endtask

   // Called at posedge+1: drive one operation, queue the model's result,
   // then compare after the next rising edge.
   task automatic step(input string tag, input logic h, input logic [1:0] mv,
                       input logic [31:0] nt, input logic rot, input logic [4:0] ad);
      exp_t e, g;
      halt = h; movement = mv; next_top = nt; rotate = rot; rotate_addr = ad;
      #1;
      check({tag, ".rv"}, 64'(rotate_value), 64'(m[ad]));
      model_step(h, mv, nt, rot, ad);
      e.t = mget(0); e.s = mget(1); e.th = mget(2);
      e.c = 6'(mcount); e.o = mov; e.u = mud;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      g.t = top; g.s = second; g.th = third; g.c = count; g.o = overflow; g.u = underflow;
      check({tag, ".top"},   64'(g.t),  64'(e.t));
      check({tag, ".sec"},   64'(g.s),  64'(e.s));
      check({tag, ".third"}, 64'(g.th), 64'(e.th));
      check({tag, ".count"}, 64'(g.c),  64'(e.c));
      check({tag, ".flags"}, 64'({g.o, g.u}), 64'({e.o, e.u}));
   endtask

   task automatic peek(input string tag, input logic [4:0] ad, input logic [31:0] exp);
      halt = 1'b1; rotate_addr = ad;
      #1;
      check(tag, 64'(rotate_value), 64'(exp));
   endtask

   // Asynchronous reset between edges; outputs must clear before any edge.
   task automatic async_reset();
      halt = 1'b1; movement = 2'b01; next_top = 32'hdead_beef;
      #1 reset = 1'b1;
      #1;
      check("rst.top",   64'(top),    64'h0);
      check("rst.sec",   64'(second), 64'h0);
      check("rst.third", 64'(third),  64'h0);
      check("rst.count", 64'(count),  64'h0);
      check("rst.flags", 64'({overflow, underflow}), 64'h0);
      model_reset();
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; halt = 1'b1; movement = 2'b00; next_top = '0;
      rotate = 1'b0; rotate_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("init.count", 64'(count), 64'h0);
      check("init.top",   64'(top),   64'h0);
      check("init.flags", 64'({overflow, underflow}), 64'h0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;

      step("push11", 1'b0, 2'b01, 32'h11, 1'b0, 5'd0);
      step("push22", 1'b0, 2'b01, 32'h22, 1'b0, 5'd0);
      step("push33", 1'b0, 2'b01, 32'h33, 1'b0, 5'd0);
      check("v1.top", 64'(top), 64'h33);
      check("v1.third", 64'(third), 64'h11);
      check("v1.count", 64'(count), 64'd3);
      check("v1.flags", 64'({overflow, underflow}), 64'h0);

      step("pop1", 1'b0, 2'b10, 32'h55, 1'b0, 5'd0);
      check("v2.top", 64'(top), 64'h55);
      check("v2.sec", 64'(second), 64'h11);
      check("v2.third", 64'(third), 64'h0);
      check("v2.count", 64'(count), 64'd2);
      step("pop2", 1'b0, 2'b11, 32'h99, 1'b0, 5'd0);
      check("v2.udf", 64'(underflow), 64'h1);
      check("v2.count0", 64'(count), 64'd0);

      async_reset();
      for (int i = 0; i < 5; i++) step("push_i", 1'b0, 2'b01, 32'(i), 1'b0, 5'd0);
      step("rot3", 1'b0, 2'b00, m[3], 1'b1, 5'd3);
      check("v3.top", 64'(top), 64'd1);
      check("v3.sec", 64'(second), 64'd4);
      check("v3.third", 64'(third), 64'd3);
      check("v3.count", 64'(count), 64'd5);
      peek("v3.e3", 5'd3, 32'd2);
      peek("v3.e4", 5'd4, 32'd0);
      step("rot0", 1'b0, 2'b00, 32'h77, 1'b1, 5'd0);
      step("rotpush", 1'b0, 2'b01, 32'h88, 1'b1, 5'd2);

      for (int i = 0; i < 3; i++) step("halt", 1'b1, 2'b01, 32'hffff, 1'b0, 5'd0);
      check("halt.count", 64'(count), 64'd6);
      check("halt.top", 64'(top), 64'h88);

      step("rotbad", 1'b0, 2'b00, 32'h1, 1'b1, 5'd20);
      step("copybad", 1'b0, 2'b01, 32'h2, 1'b1, 5'd31);

      async_reset();
      for (int i = 1; i <= 33; i++) step("fill", 1'b0, 2'b01, 32'(100 + i), 1'b0, 5'd0);
      check("v4.count", 64'(count), 64'd32);
      check("v4.ovf", 64'(overflow), 64'h1);
      check("v4.udf", 64'(underflow), 64'h0);
      check("v4.top", 64'(top), 64'd133);
      peek("v4.e31", 5'd31, 32'd102);
      step("pop2full", 1'b0, 2'b11, 32'h5, 1'b0, 5'd0);
      peek("v4.e30", 5'd30, 32'd0);
      peek("v4.e31z", 5'd31, 32'd0);

      async_reset();
      for (int i = 0; i < 60; i++) begin
         step("rand", ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3) < 2 ? 1 : $urandom_range(0, 3)),
              $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 8)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
